muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative RV32M multiply/divide unit; successor to the combinational single-cycle ALU.
- Sits beside the ALU in the execute stage and implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Uses a start/busy/done handshake.
- One bit is processed per cycle, so a normal operation finishes in XLEN+1 cycles. Divide-by-zero and signed overflow finish in 1 cycle.

Parameters:
XLEN, 32, operand/result width in bits (min 4)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand (dividend / multiplicand)
b  input  XLEN  rs2 operand (divisor / multiplier)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result/flags valid
result  output  XLEN  registered result; held until next completion
flags  output  4  [3] N = result MSB, [2] Z = result==0, [1] DZ = divide by zero, [0] OV = signed div overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, flags=0; counter and internal operand/accumulator registers cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- Edge numbering: E0 is the edge where start=1 is sampled in IDLE.
- Normal path:
  - E0, IDLE->CALC: latch op; latch |a| and |b| for signed operand positions (MULH: both; MULHSU: a only; DIV/REM: both); record result sign; counter=XLEN.
  - E1..E_XLEN, CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; counter decrements; CALC->FIX when counter reaches 0.
  - E_XLEN+1, FIX->DONE: apply sign correction and select the output word. Load result and flags.
  - MUL returns the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient is negated if operand signs differ. Remainder takes the dividend's sign.
  - done=1 for the cycle after E_XLEN+1.
  - E_XLEN+2: DONE->IDLE; done=0.
- Special path: decided at E0, combinationally from a/b/op; E0 goes IDLE->DONE with result/flags loaded, so done is high in the cycle after E0.
  - Divide by zero (op[2]=1, b==0): DIV/DIVU result all-ones; REM/REMU result = a; DZ=1.
  - Signed overflow (DIV/REM, a=100..0, b=all-ones): DIV result = a; REM result = 0; OV=1.
  - MUL ops never set DZ or OV.
- start while busy=1 is ignored: no queuing, and latched operands do not change.
- a, b and op may change freely after E0.
- start high in DONE is ignored. start is accepted again at the first edge in IDLE, so back-to-back operations are one cycle apart after done.
- N and Z are computed from the final result for all ops.
- result/flags change only on the FIX->DONE or special-path load, or on reset.
- Arithmetic is fully unsigned internally: a 2*XLEN accumulator for multiply; an XLEN+1-bit partial remainder for divide.
- No combinational path from inputs to outputs.

Test Plan (XLEN=32):
1. MUL a=7, b=0xFFFFFFFD (-3), start at E0 -> done high after E33 only; result=0xFFFFFFEB, flags=1000; busy high E0..E34.
2. High-half products -> MULH 0x80000000*0x80000000 gives 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 gives 0xFFFFFFFF.
3. Signed division, a=0xFFFFFFF9 (-7), b=2 -> DIV gives 0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1); DIVU gives 0x7FFFFFFC; REMU gives 1.
4. Special cases ->
   - DIV a=10, b=0: done after E0; result=0xFFFFFFFF; flags=1010.
   - REMU a=10, b=0: result=10; flags=0010.
   - DIV a=0x80000000, b=0xFFFFFFFF: result=0x80000000; flags=1001.
   - REM a=0x80000000, b=0xFFFFFFFF: result=0; flags=0101.
5. Handshake -> start pulsed again with new operands at E5 of a MUL -> ignored; original result delivered; exactly one done pulse. Then start held high -> next op accepted at first IDLE edge.
6. Reset mid-op -> rst_n low at E10 of a DIV -> busy, done, result and flags are 0 immediately (asynchronously); no done. A new DIVU 100/7 after release gives result=14 after 33 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with a start/busy/done handshake and a single-cycle path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(XLEN);

  // Magnitude of v when it sits in a signed operand position.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
    abs_if = (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [3:0] make_flags(input logic [XLEN-1:0] r, input logic dz, input logic ov);
    make_flags = {r[XLEN-1], (r == ZERO_X), dz, ov};
  endfunction

  logic [1:0]        state_r, state_s;
  logic [2:0]        op_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opnd_r;
  logic [XLEN-1:0]   rem_r;
  logic              neg_r;
  logic              busy_r, done_r;
  logic [XLEN-1:0]   result_r;
  logic [3:0]        flags_r;

  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
  logic              dz_s, ov_s, special_s;
  logic [XLEN-1:0]   spec_res_s, abs_a_s, abs_b_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, remf_s, fix_res_s;

  // Operand decode and the special-case early-out at the accepting edge.
  always_comb begin
    a_sgn_s    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn_s    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg_s    = a_sgn_s & a[XLEN-1];
    b_neg_s    = b_sgn_s & b[XLEN-1];
    abs_a_s    = abs_if(a, a_sgn_s);
    abs_b_s    = abs_if(b, b_sgn_s);
    case (op)
      3'b001, 3'b100: neg_s = a_neg_s ^ b_neg_s;
      3'b010, 3'b110: neg_s = a_neg_s;
      default:        neg_s = 1'b0;
    endcase
    dz_s       = op[2] && (b == ZERO_X);
    ov_s       = op[2] && !op[0] && (a == MIN_X) && (b == ONES_X);
    special_s  = dz_s || ov_s;
    if (dz_s) begin
      spec_res_s = op[1] ? a : ONES_X;
    end else if (ov_s) begin
      spec_res_s = op[1] ? ZERO_X : a;
    end else begin
      spec_res_s = ZERO_X;
    end
  end

  // Iteration step datapath and the final sign-correct/select.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_shift_s = {rem_r, acc_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    prod_s      = neg_r ? -acc_r : acc_r;
    quo_s       = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
    remf_s      = neg_r ? -rem_r : rem_r;
    case (op_r)
      3'b000:                 fix_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = quo_s;
      default:                fix_res_s = remf_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX:  state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter and operand/accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 3'b000;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {(2*XLEN){1'b0}};
      opnd_r  <= ZERO_X;
      rem_r   <= ZERO_X;
      neg_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && start && !special_s) begin
        op_r   <= op;
        cnt_r  <= CNT_INIT;
        neg_r  <= neg_s;
        opnd_r <= op[2] ? abs_b_s : abs_a_s;
        acc_r  <= {ZERO_X, (op[2] ? abs_a_s : abs_b_s)};
        rem_r  <= ZERO_X;
      end else if (state_r == ST_CALC) begin
        cnt_r <= cnt_r - CNT_ONE;
        if (!op_r[2]) begin
          acc_r <= {mul_sum_s, acc_r[XLEN-1:1]};
        end else if (!div_diff_s[XLEN]) begin
          rem_r <= div_diff_s[XLEN-1:0];
          acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], 1'b1};
        end else begin
          rem_r <= div_shift_s[XLEN-1:0];
          acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Registered handshake outputs and the result/flags load points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO_X;
      flags_r  <= 4'b0000;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
      if (state_r == ST_IDLE && start && special_s) begin
        result_r <= spec_res_s;
        flags_r  <= make_flags(spec_res_s, dz_s, ov_s);
      end else if (state_r == ST_FIX) begin
        result_r <= fix_res_s;
        flags_r  <= make_flags(fix_res_s, 1'b0, 1'b0);
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign flags  = flags_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32) with hand-computed expected values.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks;
  int n_fail;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for done (bounded) and check latency, result, flags and the return to idle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic [3:0] ef, input int elat);
    int n;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b000; a = 32'h0000_0000; b = 32'h0000_0000;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dn;
    logic [31:0] cap;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = 32'h0000_0000; b = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", result, 32'h0000_0000);
    check("rst_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_neg",  3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 4'b1000, 33);
    run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000, 33);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000, 33);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 4'b1000, 33);
    run_op("mulhu_z",  3'b011, 32'd5,         32'd7,         32'h0000_0000, 4'b0100, 33);
    run_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 4'b1000, 33);
    run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 4'b1000, 33);
    run_op("divu",     3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 4'b0000, 33);
    run_op("remu",     3'b111, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 4'b0000, 33);
    run_op("div_dz",   3'b100, 32'd10,        32'd0,         32'hFFFF_FFFF, 4'b1010, 0);
    run_op("remu_dz",  3'b111, 32'd10,        32'd0,         32'h0000_000A, 4'b0010, 0);
    run_op("div_ov",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001, 0);
    run_op("rem_ov",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0101, 0);

    // Second start during a MUL must be ignored: one done pulse, original result.
    @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op = 3'b000; a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dn = 0;
    cap = 32'h0000_0000;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        cap = result;
      end
    end
    check("hs_pulses", dn, 32'd1);
    check("hs_res", cap, 32'd15);

    // start held high: accepted again at the first edge back in IDLE.
    @(negedge clk);
    op = 3'b100; a = 32'd10; b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    check("hold_done0", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    check("hold_gap_done", {31'd0, done}, 32'd0);
    check("hold_gap_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_done1", {31'd0, done}, 32'd1);
    check("hold_res", result, 32'hFFFF_FFFF);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_res", result, 32'h0000_0000);
    check("mrst_flags", {28'd0, flags}, 32'd0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("mrst_nodone", dn, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_post", 3'b101, 32'd100, 32'd7, 32'd14, 4'b0000, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
